// File: rtl/uart_tx_buffered_pkg.sv
// rtl/uart_tx_buffered_pkg.sv - shared definitions for the buffered UART transmitter
// Holds the serializer state enum, the 8N1 frame constants and the baud divisor helper.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Cycles per serial bit; integer truncation of the ratio.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - byte FIFO feeding the UART serializer
// Ports:
//   CLK, NRST  clock, asynchronous active-low reset
//   push, din  write request and byte; ignored while full
//   pop, dout  read request and head byte (dout is valid whenever empty=0)
//   full       DEPTH bytes stored
//   empty      no bytes stored
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // Full is judged on the current count, so a push is refused even when
  // a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap DEPTH-1 -> 0 for free.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter
// Ports:
//   CLK, NRST  system clock, asynchronous active-low reset
//   wr_en      single-cycle byte write strobe
//   wr_data    byte to queue, sampled with wr_en
//   full       FIFO holds DEPTH bytes
//   empty      FIFO holds no bytes
//   busy       serializer active or bytes still queued
//   overflow   sticky: a write arrived while full and was dropped
//   uart_tx    serial line, 8N1, LSB first, idle high, driven from a flop
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       uart_tx
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    fifo_dout;
  logic          pop;
  logic          tick;

  assign pop  = (state == IDLE) && !empty;
  assign tick = (baud_cnt == LAST_TICK);
  assign busy = (state != IDLE) || !empty;

  uart_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .NRST  (NRST),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end

  // uart_tx is registered from the current state, so the line trails the
  // state by one cycle: a pop on edge p puts START on the line from p+1.
  // Every state still occupies exactly DIV cycles, so frame timing holds.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx  <= 1'b1;
          baud_cnt <= '0;
          if (!empty) begin
            shift <= fifo_dout;
            state <= START;
          end
        end
        START: begin
          uart_tx <= 1'b0;
          if (tick) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          uart_tx <= shift[0];
          if (tick) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (tick) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - scoreboard testbench for uart_tx_buffered
module tb_uart_tx_buffered;
  import uart_tx_buffered_pkg::*;

  localparam int CLK_HZ = 100;
  localparam int BAUD   = 10;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int PERIOD = FRAME_BITS * DIV + 1;

  logic       CLK = 1'b0;
  logic       NRST;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, busy, overflow, uart_tx;

  uart_tx_buffered #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .DEPTH (DEPTH)
  ) dut (
    .CLK      (CLK),
    .NRST     (NRST),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .uart_tx  (uart_tx)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_seen = 0;
  bit         mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: decodes each frame sample-by-sample, requiring every bit
  // to hold for exactly DIV cycles, and compares with the scoreboard head.
  initial begin
    logic [9:0] bits;
    logic [7:0] exp;
    bit         have, aborted, stable;
    bits = '0;
    forever begin
      @(negedge CLK);
      if (NRST === 1'b1 && uart_tx === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        frames_seen++;
        have = (exp_q.size() > 0);
        exp  = have ? exp_q.pop_front() : 8'h00;
        aborted = 1'b0;
        stable  = 1'b1;
        for (int b = 0; b < FRAME_BITS; b++) begin
          for (int k = 0; k < DIV; k++) begin
            if (b != 0 || k != 0) @(negedge CLK);
            if (NRST !== 1'b1) aborted = 1'b1;
            if (aborted) break;
            if (k == 0) bits[b] = uart_tx;
            else if (uart_tx !== bits[b]) stable = 1'b0;
          end
          if (aborted) break;
        end
        if (!aborted) begin
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected no frame (cycle %0d)", bits[8:1], cyc);
          end else begin
            check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp});
          end
          check("frame_format", {31'd0, stable && bits[0] == 1'b0 && bits[9] == 1'b1}, 32'd1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wr(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    @(posedge CLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_start(input int n, input int budget);
    int k = 0;
    while (start_q.size() < n && k < budget) begin
      @(posedge CLK); #1;
      k++;
    end
    if (start_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_start: got %0d frames expected %0d within %0d cycles", start_q.size(), n, budget);
    end
  endtask

  task automatic wait_quiet(input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && !mon_busy && busy === 1'b0 && uart_tx === 1'b1) && k < budget) begin
      @(posedge CLK); #1;
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_quiet: got %0d pending bytes expected 0 within %0d cycles", exp_q.size(), budget);
    end
  endtask

  task automatic do_reset();
    NRST = 1'b0;
    @(posedge CLK); #1;
    exp_q.delete();
    NRST = 1'b1;
  endtask

  function automatic int bad_gaps();
    int bad = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != PERIOD) bad++;
    return bad;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, e, occ, n, f0;
    bit acc;
    NRST = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);

    // Single byte straight after reset release; latency and busy timing.
    start_q.delete();
    NRST = 1'b1;
    wr(8'hA5, 1'b1);
    t0 = cyc;
    wait_start(1, 40);
    if (start_q.size() > 0) begin
      e = start_q[0];
      check("latency_start_edge", e, t0 + 2);
      to_cyc(e + FRAME_BITS * DIV - 2);
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      to_cyc(e + FRAME_BITS * DIV);
      check("busy_after_stop", {31'd0, busy}, 32'd0);
    end
    wait_quiet(400);

    // Lead frame in flight, then 16 bytes fill the FIFO and a 17th is dropped.
    start_q.delete();
    wr(8'h55, 1'b1);
    wait_start(1, 40);
    occ = 0;
    for (int i = 0; i < 16; i++) begin
      acc = (occ < DEPTH);
      wr(8'(i), acc);
      if (acc) occ++;
    end
    check("full_after_16", {31'd0, full}, 32'd1);
    check("no_overflow_16", {31'd0, overflow}, 32'd0);
    acc = (occ < DEPTH);
    wr(8'hEE, acc);
    check("overflow_17th", {31'd0, overflow}, 32'd1);
    wait_quiet(20 * PERIOD);
    check("frames_fill", start_q.size(), 17);
    check("gaps_fill", bad_gaps(), 0);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    do_reset();
    check("overflow_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO, write lands on the very edge the idle FSM pops.
    start_q.delete();
    wr(8'h11, 1'b1);
    wait_start(1, 40);
    e = (start_q.size() > 0) ? start_q[0] : cyc;
    occ = 0;
    for (int i = 0; i < 16; i++) begin
      wr(8'($urandom), 1'b1);
      occ++;
    end
    to_cyc(e + FRAME_BITS * DIV - 1);
    check("full_before_pop", {31'd0, full}, 32'd1);
    wr(8'h99, occ < DEPTH);
    check("overflow_on_pop", {31'd0, overflow}, 32'd1);
    check("not_full_after_pop", {31'd0, full}, 32'd0);
    check("not_empty_after_pop", {31'd0, empty}, 32'd0);
    wait_quiet(20 * PERIOD);
    check("frames_pop_race", start_q.size(), 17);
    check("gaps_pop_race", bad_gaps(), 0);
    do_reset();

    // Reset during data bit 3 of 0x3C with two bytes queued.
    start_q.delete();
    wr(8'h3C, 1'b1);
    wait_start(1, 40);
    e = (start_q.size() > 0) ? start_q[0] : cyc;
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    to_cyc(e + DIV * 4 + 4);
    NRST = 1'b0;
    #1;
    check("abort_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("abort_empty", {31'd0, empty}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(posedge CLK); #1;
    NRST = 1'b1;
    f0 = frames_seen;
    repeat (3 * PERIOD) @(posedge CLK);
    #1;
    check("no_frames_after_abort", frames_seen, f0);
    check("line_idle_after_abort", {31'd0, uart_tx}, 32'd1);

    // Random bytes roughly every 100 cycles; pointers wrap several times.
    start_q.delete();
    for (int i = 0; i < 40; i++) begin
      wr(8'($urandom), 1'b1);
      repeat (99 + $urandom_range(0, 30)) @(posedge CLK);
      #1;
    end
    wait_quiet(4 * PERIOD);
    check("frames_spaced", start_q.size(), 40);
    check("no_overflow_spaced", {31'd0, overflow}, 32'd0);

    // Random bursts from idle: the first pop keeps the FIFO below full.
    for (int r = 0; r < 3; r++) begin
      start_q.delete();
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) wr(8'($urandom), 1'b1);
      check("burst_not_full", {31'd0, full}, 32'd0);
      wait_quiet((n + 2) * PERIOD);
      check("burst_frames", start_q.size(), n);
      check("burst_gaps", bad_gaps(), 0);
    end
    check("no_overflow_bursts", {31'd0, overflow}, 32'd0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
